// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//   Programmable pulse-train generator. It produces a registered PULSE waveform
//   with a programmable period and high time, either continuously or as a
//   one-shot run. PULSE drives the CLK input of a downstream ripple-counter
//   stage, and that stage counts PULSE rising edges.
//
//   Optional feature macro: PULSE_GEN_BURST_EN
//     defined   : adds the burst port. A one-shot run emits max(burst,1) periods.
//     undefined : there is no burst port, and a one-shot run is exactly one period.
//
// Parameters
//   WIDTH      width of period, high_time, burst and the cycle counter
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level; starts a run from IDLE (ignored while busy)
//   stop       level; aborts a run, and has priority over start
//   mode       0 = continuous, 1 = one-shot (captured at run start)
//   period     period in clk cycles; 0 is not a legal value
//   high_time  pulse high cycles per period (clamped to period)
//   burst      periods per one-shot run (only with PULSE_GEN_BURST_EN)
//   pulse      registered pulse output
//   busy       high while running
//   done       one-cycle strobe at the normal end of a one-shot run
// ---------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] high_time,
`ifdef PULSE_GEN_BURST_EN
  input  logic [WIDTH-1:0] burst,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN_HIGH, RUN_LOW} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] h_reg, h_next;
  logic             mode_reg, mode_next;
  logic             pulse_reg, pulse_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef PULSE_GEN_BURST_EN
  logic [WIDTH-1:0] burst_cnt_reg, burst_cnt_next;
`endif

  // The effective high time is clamped to the period. This makes H==P mean
  // that the output is "always high".
  logic [WIDTH-1:0] h_eff;
  logic [WIDTH-1:0] cnt_plus;
  logic             last_period;

  assign h_eff    = (high_time > period) ? period : high_time;
  assign cnt_plus = cnt_reg + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      p_reg         <= '0;
      h_reg         <= '0;
      mode_reg      <= 1'b0;
      pulse_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
      burst_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      p_reg         <= p_next;
      h_reg         <= h_next;
      mode_reg      <= mode_next;
      pulse_reg     <= pulse_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
`ifdef PULSE_GEN_BURST_EN
      burst_cnt_reg <= burst_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    p_next      = p_reg;
    h_next      = h_reg;
    mode_next   = mode_reg;
    pulse_next  = pulse_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    last_period = 1'b1;
`ifdef PULSE_GEN_BURST_EN
    burst_cnt_next = burst_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start && !stop && (period != '0)) begin
          p_next     = period;
          h_next     = h_eff;
          mode_next  = mode;
          cnt_next   = '0;
          busy_next  = 1'b1;
          pulse_next = (h_eff != '0);
          state_next = (h_eff != '0) ? RUN_HIGH : RUN_LOW;
`ifdef PULSE_GEN_BURST_EN
          burst_cnt_next = (burst == '0) ? WIDTH'(1) : burst;
`endif
        end
      end

      RUN_HIGH, RUN_LOW: begin
        if (stop) begin
          // Abort: the partial period is thrown away and done stays low.
          state_next = IDLE;
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          cnt_next   = '0;
`ifdef PULSE_GEN_BURST_EN
          burst_cnt_next = '0;
`endif
        end else if (cnt_reg == p_reg - WIDTH'(1)) begin
          // Period boundary. The boundary check comes before the high/low
          // check, so when H==P the output stays high across periods.
`ifdef PULSE_GEN_BURST_EN
          if (burst_cnt_reg > WIDTH'(1)) begin
            last_period    = 1'b0;
            burst_cnt_next = burst_cnt_reg - WIDTH'(1);
          end
`endif
          cnt_next = '0;
          if (mode_reg && last_period) begin
            state_next = IDLE;
            pulse_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else if (period == '0) begin
            // A zero period loaded at a boundary ends the run quietly.
            state_next = IDLE;
            pulse_next = 1'b0;
            busy_next  = 1'b0;
          end else begin
            p_next     = period;
            h_next     = h_eff;
            pulse_next = (h_eff != '0);
            state_next = (h_eff != '0) ? RUN_HIGH : RUN_LOW;
          end
        end else begin
          cnt_next = cnt_plus;
          if (cnt_plus == h_reg) begin
            state_next = RUN_LOW;
            pulse_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        pulse_next = 1'b0;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  assign pulse = pulse_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//   Directed, self-checking bench for pulse_train_gen.
//   Inputs are driven on falling edges and outputs are sampled on falling
//   edges. Cycle k is the k-th falling edge after the rising edge that
//   sampled start.
//   A 4-bit counter model counts pulse rising edges, standing in for the
//   downstream ripple-counter stage.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
`ifdef PULSE_GEN_BURST_EN
  logic [WIDTH-1:0] burst;
`endif
  logic             pulse;
  logic             busy;
  logic             done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] rc;
  logic       rc_clr;

  pulse_train_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .period    (period),
    .high_time (high_time),
`ifdef PULSE_GEN_BURST_EN
    .burst     (burst),
`endif
    .pulse     (pulse),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge pulse or posedge rc_clr) begin
    if (rc_clr) rc <= 4'd0;
    else        rc <= rc + 4'd1;
  end

  // Captures pulse/busy/done for n cycles into bit vectors (bit i = cycle i).
  // The task returns with the time positioned at the sample point of cycle n-1.
  task automatic capture(input int n, output logic [31:0] pv,
                         output logic [31:0] bv, output logic [31:0] dv);
    pv = '0; bv = '0; dv = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      pv[i] = pulse;
      bv[i] = busy;
      dv[i] = done;
    end
  endtask

  task automatic start_run(input logic m_i, input logic [WIDTH-1:0] p_i,
                           input logic [WIDTH-1:0] h_i);
    mode = m_i; period = p_i; high_time = h_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; mode = 0; period = 0; high_time = 0;
`ifdef PULSE_GEN_BURST_EN
    burst = 0;
`endif
    rc_clr = 1'b1;
    #1;
    tests_run++;
    if ({pulse, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_async: {pulse,busy,done}=%b required 000", {pulse, busy, done});
    end
    rc_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({pulse, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_clocked: {pulse,busy,done}=%b required 000", {pulse, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({pulse, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_release: {pulse,busy,done}=%b required 000", {pulse, busy, done});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_continuous();
    logic [31:0] pv, bv, dv;
    rc_clr = 1'b1; #1; rc_clr = 1'b0;
    start_run(1'b0, 8'd4, 8'd1);
    capture(16, pv, bv, dv);
    tests_run++;
    if (pv[15:0] !== 16'h1111) begin
      tests_failed++;
      $display("FAIL cont_pulse: pulse=%h required 1111", pv[15:0]);
    end
    tests_run++;
    if (bv[15:0] !== 16'hFFFF || dv[15:0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL cont_busy_done: busy=%h done=%h required FFFF 0000", bv[15:0], dv[15:0]);
    end
    tests_run++;
    if (rc !== 4'd4) begin
      tests_failed++;
      $display("FAIL cont_ripple: count=%0d required 4", rc);
    end
    end_run();
    tests_run++;
    if ({pulse, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL cont_stop: {pulse,busy,done}=%b required 000", {pulse, busy, done});
    end
    $display("[TB] test_continuous done");
  endtask

  task automatic test_one_shot();
    logic [31:0] pv, bv, dv;
    start_run(1'b1, 8'd5, 8'd2);
    capture(10, pv, bv, dv);
    tests_run++;
    if (pv[9:0] !== 10'b0000000011) begin
      tests_failed++;
      $display("FAIL oneshot_pulse: pulse=%b required 0000000011", pv[9:0]);
    end
    tests_run++;
    if (bv[9:0] !== 10'b0000011111) begin
      tests_failed++;
      $display("FAIL oneshot_busy: busy=%b required 0000011111", bv[9:0]);
    end
    tests_run++;
    if (dv[9:0] !== 10'b0000100000) begin
      tests_failed++;
      $display("FAIL oneshot_done: done=%b required 0000100000", dv[9:0]);
    end
    @(negedge clk);
    $display("[TB] test_one_shot done");
  endtask

  task automatic test_boundaries();
    logic [31:0] pv, bv, dv;
    // A zero period with start held must never start a run.
    mode = 1'b0; period = 8'd0; high_time = 8'd1; start = 1'b1;
    @(negedge clk);
    capture(4, pv, bv, dv);
    start = 1'b0;
    tests_run++;
    if (bv[3:0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL period_zero: busy=%b required 0000", bv[3:0]);
    end
    // HIGH_TIME greater than PERIOD is clamped, so pulse is constant high.
    start_run(1'b0, 8'd3, 8'd7);
    capture(9, pv, bv, dv);
    tests_run++;
    if (pv[8:0] !== 9'h1FF || bv[8:0] !== 9'h1FF) begin
      tests_failed++;
      $display("FAIL high_ge_period: pulse=%h busy=%h required 1ff 1ff", pv[8:0], bv[8:0]);
    end
    end_run();
    // A zero high time still times the periods and still fires done.
    start_run(1'b1, 8'd3, 8'd0);
    capture(5, pv, bv, dv);
    tests_run++;
    if (pv[4:0] !== 5'b00000) begin
      tests_failed++;
      $display("FAIL high_zero_pulse: pulse=%b required 00000", pv[4:0]);
    end
    tests_run++;
    if (bv[4:0] !== 5'b00111 || dv[4:0] !== 5'b01000) begin
      tests_failed++;
      $display("FAIL high_zero_done: busy=%b done=%b required 00111 01000", bv[4:0], dv[4:0]);
    end
    @(negedge clk);
    // In continuous mode a zero period loaded at the boundary returns to idle without done.
    start_run(1'b0, 8'd2, 8'd1);
    period = 8'd0;
    @(negedge clk);
    capture(3, pv, bv, dv);
    tests_run++;
    if (bv[2:0] !== 3'b001 || dv[2:0] !== 3'b000 || pv[2:0] !== 3'b000) begin
      tests_failed++;
      $display("FAIL cont_period_zero: busy=%b done=%b pulse=%b required 001 000 000",
               bv[2:0], dv[2:0], pv[2:0]);
    end
    @(negedge clk);
    $display("[TB] test_boundaries done");
  endtask

  task automatic test_stop();
    logic [31:0] pv, bv, dv;
    start_run(1'b0, 8'd6, 8'd3);
    @(negedge clk);
    tests_run++;
    if (pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_pre: pulse=%b required 1", pulse);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    capture(4, pv, bv, dv);
    tests_run++;
    if (pv[3:0] !== 4'b0000 || bv[3:0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL stop_abort: pulse=%b busy=%b required 0000 0000", pv[3:0], bv[3:0]);
    end
    tests_run++;
    if (dv[3:0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL stop_no_done: done=%b required 0000", dv[3:0]);
    end
    // When start and stop are both high in idle, the block must stay idle.
    mode = 1'b0; period = 8'd4; high_time = 8'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    capture(3, pv, bv, dv);
    start = 1'b0; stop = 1'b0;
    tests_run++;
    if (bv[2:0] !== 3'b000 || pv[2:0] !== 3'b000) begin
      tests_failed++;
      $display("FAIL start_stop_idle: busy=%b pulse=%b required 000 000", bv[2:0], pv[2:0]);
    end
    @(negedge clk);
    $display("[TB] test_stop done");
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] pv, bv, dv;
    start_run(1'b0, 8'd6, 8'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pulse, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_run: {pulse,busy,done}=%b required 000", {pulse, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1'b0, 8'd6, 8'd3);
    capture(7, pv, bv, dv);
    tests_run++;
    if (pv[6:0] !== 7'b1000111) begin
      tests_failed++;
      $display("FAIL reset_restart: pulse=%b required 1000111", pv[6:0]);
    end
    end_run();
    $display("[TB] test_reset_mid_run done");
  endtask

`ifdef PULSE_GEN_BURST_EN
  task automatic test_burst();
    logic [31:0] pv, bv, dv;
    burst = 8'd3;
    start_run(1'b1, 8'd2, 8'd1);
    capture(8, pv, bv, dv);
    tests_run++;
    if (pv[7:0] !== 8'b00010101 || bv[7:0] !== 8'b00111111 || dv[7:0] !== 8'b01000000) begin
      tests_failed++;
      $display("FAIL burst3: pulse=%b busy=%b done=%b required 00010101 00111111 01000000",
               pv[7:0], bv[7:0], dv[7:0]);
    end
    burst = 8'd0;
    start_run(1'b1, 8'd2, 8'd1);
    capture(4, pv, bv, dv);
    tests_run++;
    if (pv[3:0] !== 4'b0001 || bv[3:0] !== 4'b0011 || dv[3:0] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL burst0: pulse=%b busy=%b done=%b required 0001 0011 0100",
               pv[3:0], bv[3:0], dv[3:0]);
    end
    burst = 8'd3;
    start_run(1'b1, 8'd2, 8'd1);
    period = 8'd4;
    @(negedge clk);
    capture(11, pv, bv, dv);
    tests_run++;
    if (pv[10:0] !== 11'b00000100010 || bv[10:0] !== 11'b00111111111 ||
        dv[10:0] !== 11'b01000000000) begin
      tests_failed++;
      $display("FAIL burst_period_change: pulse=%b busy=%b done=%b required 00000100010 00111111111 01000000000",
               pv[10:0], bv[10:0], dv[10:0]);
    end
    burst = 8'd0;
    @(negedge clk);
    $display("[TB] test_burst done");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_one_shot();
    test_boundaries();
    test_stop();
    test_reset_mid_run();
`ifdef PULSE_GEN_BURST_EN
    test_burst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
